// File: rtl/amiq_mux_pkg.sv
// rtl/amiq_mux_pkg.sv - shared definitions for the registered 2:1 mux
//
// Purpose: default data width and the select encoding used by the mux
//          datapath and its output register wrapper.
// Ports:   none (package)

package amiq_mux_pkg;

  localparam int AMIQ_MUX_DEF_WIDTH = 1;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } amiq_mux_sel_e;

endpackage : amiq_mux_pkg

// File: rtl/amiq_mux_2_1_comb.sv
// rtl/amiq_mux_2_1_comb.sv - combinational WIDTH-bit 2:1 select
//
// Purpose: pure combinational selection between two data words.
// Ports:
//   sel   in   1      0 -> in0, 1 -> in1
//   in0   in   WIDTH  data input 0
//   in1   in   WIDTH  data input 1
//   data  out  WIDTH  selected word (unregistered)

module amiq_mux_2_1_comb
  import amiq_mux_pkg::*;
#(
  parameter int WIDTH = AMIQ_MUX_DEF_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] data
);

  always_comb begin
    data = in0;
    case (amiq_mux_sel_e'(sel))
      SEL_IN0: data = in0;
      SEL_IN1: data = in1;
    endcase
  end

endmodule : amiq_mux_2_1_comb

// File: rtl/amiq_mux_2_1.sv
// rtl/amiq_mux_2_1.sv - registered 2:1 multiplexer
//
// Purpose: captures in0 (sel=0) or in1 (sel=1) into the output register on
//          every rising clock edge; one cycle of latency, no handshake.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous reset, active-low; loads OUT_RST_VAL
//   sel    in   1      0 -> in0, 1 -> in1
//   in0    in   WIDTH  data input 0
//   in1    in   WIDTH  data input 1
//   out    out  WIDTH  registered mux output

module amiq_mux_2_1
  import amiq_mux_pkg::*;
#(
  parameter int               WIDTH       = AMIQ_MUX_DEF_WIDTH,
  parameter logic [WIDTH-1:0] OUT_RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("amiq_mux_2_1: WIDTH must be >= 1");
    end
    if ($bits(OUT_RST_VAL) != WIDTH) begin : g_bad_rst_val
      $error("amiq_mux_2_1: OUT_RST_VAL must be exactly WIDTH bits");
    end
  endgenerate

  logic [WIDTH-1:0] mux_data;

  amiq_mux_2_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .sel  (sel),
    .in0  (in0),
    .in1  (in1),
    .data (mux_data)
  );

  // Reset wins over select and data; nothing from before reset survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= OUT_RST_VAL;
    end else begin
      out <= mux_data;
    end
  end

endmodule : amiq_mux_2_1

// File: tb/tb_amiq_mux_2_1.sv
// tb/tb_amiq_mux_2_1.sv - scoreboard bench for the registered 2:1 mux
//
// Purpose: drives directed vectors into a 1-bit and an 8-bit instance,
//          queues hand-computed expectations, and compares in a monitor.
// Ports:   none (top-level bench)

module tb_amiq_mux_2_1;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       n_in0, n_in1, n_out;
  logic [7:0] w_in0, w_in1, w_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       rst;
    logic       sel;
    logic       n0;
    logic       n1;
    logic       nexp;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] wexp;
    logic       mid;
  } vec_t;

  typedef struct {
    int         idx;
    logic       nexp;
    logic [7:0] wexp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  amiq_mux_2_1 dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .in0   (n_in0),
    .in1   (n_in1),
    .out   (n_out)
  );

  amiq_mux_2_1 #(
    .WIDTH       (8),
    .OUT_RST_VAL (8'h5A)
  ) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .in0   (w_in0),
    .in1   (w_in1),
    .out   (w_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic s, input logic n0, input logic n1,
                     input logic nexp, input logic [7:0] w0, input logic [7:0] w1,
                     input logic [7:0] wexp, input logic mid);
    vec_t v;
    v.rst = rst; v.sel = s; v.n0 = n0; v.n1 = n1; v.nexp = nexp;
    v.w0 = w0; v.w1 = w1; v.wexp = wexp; v.mid = mid;
    vecs.push_back(v);
  endtask

  // Monitor: every edge is a valid transfer, so compare once per edge when an
  // expectation is pending.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_w1", e.idx, {31'b0, n_out}, {31'b0, e.nexp});
      check("out_w8", e.idx, {24'b0, w_out}, {24'b0, e.wexp});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; sel = 1'b1;
    n_in0 = 1'b1; n_in1 = 1'b1;
    w_in0 = 8'hFF; w_in1 = 8'hFF;

    //   rst sel n0 n1 nexp  w0     w1     wexp   mid
    // reset held two edges; sel/data must be ignored
    add(0, 1, 1, 1, 0, 8'hFF, 8'hFF, 8'h5A, 0);
    add(0, 1, 1, 1, 0, 8'hFF, 8'hFF, 8'h5A, 0);
    // sel=0 passes in0
    add(1, 0, 1, 0, 1, 8'hA5, 8'h3C, 8'hA5, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h3C, 8'h00, 0);
    // sel=1 passes in1, then sel toggles every cycle
    add(1, 1, 0, 1, 1, 8'h00, 8'h3C, 8'h3C, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'h3C, 8'h00, 0);
    add(1, 1, 0, 1, 1, 8'h00, 8'h3C, 8'h3C, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'h3C, 8'h00, 0);
    add(1, 1, 0, 1, 1, 8'h00, 8'h3C, 8'h3C, 0);
    // in1 changes mid-cycle: out must hold until the next edge
    add(1, 1, 0, 0, 0, 8'h00, 8'hC3, 8'hC3, 1);
    add(1, 1, 0, 1, 1, 8'h00, 8'h3C, 8'h3C, 1);
    // reset mid-stream for one edge, then release with sel=1, in1=1
    add(0, 1, 0, 1, 0, 8'h00, 8'h3C, 8'h5A, 0);
    add(1, 1, 0, 1, 1, 8'h00, 8'h3C, 8'h3C, 0);
    // exhaustive (sel,in0,in1) sweep; wide uses in0 in {00,A5}, in1 in {00,3C}
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'h3C, 8'h00, 0);
    add(1, 0, 1, 0, 1, 8'hA5, 8'h00, 8'hA5, 0);
    add(1, 0, 1, 1, 1, 8'hA5, 8'h3C, 8'hA5, 0);
    add(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 0, 1, 1, 8'h00, 8'h3C, 8'h3C, 0);
    add(1, 1, 1, 0, 0, 8'hA5, 8'h00, 8'h00, 0);
    add(1, 1, 1, 1, 1, 8'hA5, 8'h3C, 8'h3C, 0);
    // reset after the sweep must override the last transfer
    add(0, 0, 1, 1, 0, 8'hA5, 8'h3C, 8'h5A, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst;
      sel   = vecs[i].sel;
      n_in0 = vecs[i].n0;
      n_in1 = vecs[i].n1;
      w_in0 = vecs[i].w0;
      w_in1 = vecs[i].w1;
      e.idx  = i;
      e.nexp = vecs[i].nexp;
      e.wexp = vecs[i].wexp;
      exp_q.push_back(e);
      if (vecs[i].mid && i > 0) begin
        #2;
        check("hold_w1", i, {31'b0, n_out}, {31'b0, vecs[i-1].nexp});
        check("hold_w8", i, {24'b0, w_out}, {24'b0, vecs[i-1].wexp});
      end
    end

    repeat (2) @(negedge clk);
    check("drain", vecs.size(), exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_amiq_mux_2_1
